// File: rtl/irq_ctrl.sv
// Interrupt controller feeding cp0's ir_in: synchronises external lines, latches rising
// edges as pending bits, masks and priority-encodes them, and runs a REQ/SERVICE handshake.
module irq_ctrl #(
   parameter int N_IRQ       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int IDX_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] irq_raw,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   output logic [N_IRQ-1:0] mask,
   output logic [N_IRQ-1:0] pending,
   output logic             ir_req,
   output logic [IDX_W-1:0] ir_cause,
   input  logic             ir_taken,
   input  logic             eret,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             ir_req_nx;
   logic [IDX_W-1:0] cause_nx;

   logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [N_IRQ-1:0] s_d;
   logic [N_IRQ-1:0] edges;
   logic [N_IRQ-1:0] eligible;
   logic [N_IRQ-1:0] cause_bit;
   logic [N_IRQ-1:0] clr;
   logic             cause_eligible;
   logic [IDX_W-1:0] sel;

   // Synchronisers plus one delayed copy for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         s_d <= '0;
      end else begin
         sync_q[0] <= irq_raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         s_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edges          = sync_q[SYNC_STAGES-1] & ~s_d;
   assign eligible       = pending & mask;
   assign cause_bit      = N_IRQ'(1) << ir_cause;
   assign cause_eligible = |(eligible & cause_bit);

   // Lowest eligible index wins
   always_comb begin
      sel = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) sel = IDX_W'(i);
      end
   end

   always_comb begin
      state_nx  = state;
      ir_req_nx = ir_req;
      cause_nx  = ir_cause;
      clr       = '0;
      case (state)
         IDLE: begin
            if (|eligible) begin
               cause_nx  = sel;
               ir_req_nx = 1'b1;
               state_nx  = REQ;
            end
         end
         REQ: begin
            // Acceptance beats withdrawal when both happen on the same edge
            if (ir_taken) begin
               ir_req_nx = 1'b0;
               clr       = cause_bit;
               state_nx  = SERVICE;
            end else if (!cause_eligible) begin
               ir_req_nx = 1'b0;
               state_nx  = IDLE;
            end
         end
         SERVICE: begin
            if (eret) state_nx = IDLE;
         end
         default: begin
            ir_req_nx = 1'b0;
            state_nx  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ir_req   <= 1'b0;
         ir_cause <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         ir_req   <= ir_req_nx;
         ir_cause <= cause_nx;
         busy     <= (state_nx != IDLE);
      end
   end

   // A fresh edge on the bit being cleared is kept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         mask    <= '0;
      end else begin
         pending <= (pending & ~clr) | edges;
         if (mask_we) mask <= mask_wdata;
      end
   end

endmodule
